// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard control: operand forwarding, load-use stall, branch flush,
// and a small FSM that holds EX while a multi-cycle mul/div op completes.
module ex_hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             ex_is_md,
    input  logic             ex_br_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_RegWEn,
    input  logic [4:0]       wb_rd,
    input  logic             wb_RegWEn,
    input  logic             md_done,
    output logic [1:0]       ForwardASel,
    output logic [1:0]       ForwardBSel,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_mem,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             md_start,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {StIdle, StMdWait, StMdDrain} state_e;

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(MD_TIMEOUT - 1);

    state_e           state_q;
    logic [CNT_W-1:0] md_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             md_err_q;

    logic load_use;
    logic br_flush;
    logic md_go;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] m_rd,
                                           input logic m_we, input logic [4:0] w_rd,
                                           input logic w_we);
        // MEM holds the younger result, so it wins over WB
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) return 2'b10;
        if (w_we && (w_rd != 5'd0) && (w_rd == rs)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        load_use = ex_valid && ex_MemRead && (ex_rd != 5'd0) && id_valid &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        br_flush = ex_valid && ex_br_taken;
        md_go    = ex_valid && ex_is_md;

        ForwardASel = 2'b00;
        ForwardBSel = 2'b00;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_mem  = 1'b0;
        bubble_ex   = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        md_start    = 1'b0;

        if (rst_n) begin
            ForwardASel = fwd_sel(ex_rs1, mem_rd, mem_RegWEn, wb_rd, wb_RegWEn);
            ForwardBSel = fwd_sel(ex_rs2, mem_rd, mem_RegWEn, wb_rd, wb_RegWEn);
            unique case (state_q)
                StIdle: begin
                    flush_id = br_flush;
                    flush_ex = br_flush;
                    // A taken branch discards the dependent instr, so no stall needed
                    if (!br_flush && load_use) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end
                    md_start = md_go;
                end
                StMdWait: begin
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    bubble_mem = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
            md_err_q    <= 1'b0;
        end else begin
            if (stall_if && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            case (state_q)
                StIdle: begin
                    if (md_go) begin
                        state_q  <= StMdWait;
                        md_cnt_q <= '0;
                    end
                end
                StMdWait: begin
                    md_cnt_q <= md_cnt_q + CNT_W'(1);
                    if (md_done) begin
                        state_q <= StMdDrain;
                    end else if (md_cnt_q == TimeoutLast) begin
                        state_q  <= StMdDrain;
                        md_err_q <= 1'b1;
                    end
                end
                StMdDrain: begin
                    md_cnt_q <= '0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign md_err    = md_err_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: a default instance plus a short-timeout,
// narrow-counter instance, both driven from the same inputs.
module tb_ex_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid, ex_valid, ex_MemRead, ex_is_md, ex_br_taken;
    logic       mem_RegWEn, wb_RegWEn, md_done;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;

    logic [1:0] fwd_a, fwd_b;
    logic       stall_if, stall_id, bubble_mem, bubble_ex, flush_id, flush_ex, md_start, md_err;
    logic [7:0] stall_cnt;

    logic [1:0] t_fwd_a, t_fwd_b;
    logic       t_stall_if, t_stall_id, t_bubble_mem, t_bubble_ex, t_flush_id, t_flush_ex;
    logic       t_md_start, t_md_err;
    logic [2:0] t_stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    ex_hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_MemRead(ex_MemRead), .ex_is_md(ex_is_md), .ex_br_taken(ex_br_taken),
        .mem_rd(mem_rd), .mem_RegWEn(mem_RegWEn), .wb_rd(wb_rd), .wb_RegWEn(wb_RegWEn),
        .md_done(md_done), .ForwardASel(fwd_a), .ForwardBSel(fwd_b), .stall_if(stall_if),
        .stall_id(stall_id), .bubble_mem(bubble_mem), .bubble_ex(bubble_ex),
        .flush_id(flush_id), .flush_ex(flush_ex), .md_start(md_start), .md_err(md_err),
        .stall_cnt(stall_cnt)
    );

    ex_hazard_ctrl #(.MD_TIMEOUT(4), .CNT_W(3)) dut_t (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_MemRead(ex_MemRead), .ex_is_md(ex_is_md), .ex_br_taken(ex_br_taken),
        .mem_rd(mem_rd), .mem_RegWEn(mem_RegWEn), .wb_rd(wb_rd), .wb_RegWEn(wb_RegWEn),
        .md_done(md_done), .ForwardASel(t_fwd_a), .ForwardBSel(t_fwd_b),
        .stall_if(t_stall_if), .stall_id(t_stall_id), .bubble_mem(t_bubble_mem),
        .bubble_ex(t_bubble_ex), .flush_id(t_flush_id), .flush_ex(t_flush_ex),
        .md_start(t_md_start), .md_err(t_md_err), .stall_cnt(t_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        ex_MemRead = 0; ex_is_md = 0; ex_br_taken = 0;
        mem_rd = 0; mem_RegWEn = 0; wb_rd = 0; wb_RegWEn = 0; md_done = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        tick();
        rst_n = 1;
        #1;
    endtask

    initial begin
        // Reset: hazard-provoking inputs must not leak to outputs
        rst_n = 0;
        clear_inputs();
        mem_RegWEn = 1; mem_rd = 5; ex_rs1 = 5;
        ex_valid = 1; ex_MemRead = 1; ex_rd = 7; id_valid = 1; id_rs2 = 7;
        tick();
        tick();
        chk("rst_fwd_a", fwd_a, 2'b00);
        chk("rst_stall_if", stall_if, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_md_err", md_err, 0);
        chk("rst_t_md_err", t_md_err, 0);
        clear_inputs();
        rst_n = 1;
        tick();

        // Forwarding priority and x0 guard
        mem_rd = 5; wb_rd = 5; ex_rs1 = 5; mem_RegWEn = 1; wb_RegWEn = 1;
        #1 chk("fwd_a_mem_prio", fwd_a, 2'b10);
        mem_RegWEn = 0;
        #1 chk("fwd_a_wb", fwd_a, 2'b01);
        mem_rd = 0; mem_RegWEn = 1; ex_rs2 = 0; wb_RegWEn = 0;
        #1 chk("fwd_b_x0", fwd_b, 2'b00);
        ex_rs2 = 9; wb_rd = 9; wb_RegWEn = 1;
        #1 chk("fwd_b_wb", fwd_b, 2'b01);
        clear_inputs();
        tick();

        // Load-use stall for one cycle
        ex_valid = 1; ex_MemRead = 1; ex_rd = 7; id_valid = 1; id_rs1 = 3; id_rs2 = 7;
        #1;
        chk("lu_stall_if", stall_if, 1);
        chk("lu_stall_id", stall_id, 1);
        chk("lu_bubble_ex", bubble_ex, 1);
        chk("lu_bubble_mem", bubble_mem, 0);
        tick();
        ex_MemRead = 0; ex_rd = 0;
        #1;
        chk("lu_released", stall_if, 0);
        chk("lu_stall_cnt", stall_cnt, 1);

        // Load-use plus taken branch: flush only
        ex_MemRead = 1; ex_rd = 7; ex_br_taken = 1;
        #1;
        chk("br_flush_id", flush_id, 1);
        chk("br_flush_ex", flush_ex, 1);
        chk("br_no_stall", stall_if, 0);
        chk("br_no_bubble", bubble_ex, 0);
        clear_inputs();
        tick();
        chk("br_stall_cnt", stall_cnt, 1);

        // md_done while idle is ignored
        md_done = 1;
        tick();
        md_done = 0;
        #1 chk("idle_done_ignored", stall_if, 0);

        // MD op: md_done in the fifth MD_WAIT cycle
        do_reset();
        ex_valid = 1; ex_is_md = 1;
        #1;
        chk("md_start", md_start, 1);
        chk("md_start_nostall", stall_if, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            md_done = (i == 5);
            ex_br_taken = (i == 2);
            #1;
            chk("md_wait_stall", stall_if, 1);
            chk("md_wait_bubble_mem", bubble_mem, 1);
            chk("md_wait_no_start", md_start, 0);
            chk("md_wait_no_flush", flush_id, 0);
        end
        tick();
        md_done = 0; ex_br_taken = 0;
        #1;
        chk("md_drain_stall", stall_if, 0);
        chk("md_drain_bubble_mem", bubble_mem, 0);
        chk("md_drain_no_start", md_start, 0);
        chk("md_drain_stall_cnt", stall_cnt, 5);
        tick();
        ex_valid = 0; ex_is_md = 0;
        #1;
        chk("md_idle_stall", stall_if, 0);
        chk("md_idle_stall_cnt", stall_cnt, 5);
        chk("md_idle_err", md_err, 0);

        // Timeout on the MD_TIMEOUT=4 instance, then md_err stickiness and saturation
        do_reset();
        ex_valid = 1; ex_is_md = 1;
        #1 chk("to_md_start", t_md_start, 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            ex_valid = 0; ex_is_md = 0;
            #1;
            chk("to_wait_stall", t_stall_if, 1);
            chk("to_wait_err", t_md_err, 0);
        end
        tick();
        chk("to_drain_stall", t_stall_if, 0);
        chk("to_drain_bubble_mem", t_bubble_mem, 0);
        chk("to_drain_err", t_md_err, 1);
        tick();
        chk("to_idle_stall_cnt", t_stall_cnt, 4);
        ex_valid = 1; ex_is_md = 1;
        #1 chk("to_restart", t_md_start, 1);
        tick();
        ex_valid = 0; ex_is_md = 0; md_done = 1;
        #1 chk("to_op2_stall", t_stall_if, 1);
        tick();
        md_done = 0;
        #1;
        chk("to_op2_drain", t_stall_if, 0);
        chk("to_err_sticky", t_md_err, 1);
        tick();
        chk("to_op2_stall_cnt", t_stall_cnt, 5);
        ex_valid = 1; ex_is_md = 1;
        #1 chk("to_op3_start", t_md_start, 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            ex_valid = 0; ex_is_md = 0;
        end
        tick();
        chk("sat_stall_cnt", t_stall_cnt, 7);
        tick();
        chk("sat_no_wrap", t_stall_cnt, 7);
        chk("sat_err_sticky", t_md_err, 1);

        // Reset in the middle of MD_WAIT
        do_reset();
        ex_valid = 1; ex_is_md = 1;
        tick();
        ex_valid = 0; ex_is_md = 0;
        #1 chk("mid_wait_stall", stall_if, 1);
        tick();
        chk("mid_wait_stall_cnt", stall_cnt, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_forced_stall", stall_if, 0);
        chk("mid_rst_forced_bubble", bubble_mem, 0);
        tick();
        rst_n = 1;
        #1;
        chk("mid_rst_idle_stall", stall_if, 0);
        chk("mid_rst_idle_bubble", bubble_mem, 0);
        chk("mid_rst_stall_cnt", stall_cnt, 0);
        chk("mid_rst_t_err_cleared", t_md_err, 0);
        ex_valid = 1; ex_is_md = 1;
        #1 chk("mid_rst_start", md_start, 1);
        clear_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
